wm_keystream_gen: RTL and testbench
===================================

# wm_keystream_gen

Parametrised key-seeded watermark keystream generator. A Galois LFSR of configurable width and polynomial is loaded from a key, optionally warmed up, then streams a programmable number of SYM_W-bit watermark symbols over a valid/ready handshake. It sits between key/control registers and the embedding datapath, which pulls one symbol per pixel. It supersedes the fixed 8-bit, 2-bit-output, free-running generator with length control, back-pressure, seed protection and a completion pulse.

## Interface
- KEY_W, 16, LFSR/key width (4..32)
- TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1); width KEY_W
- SYM_W, 2, bits per output symbol (1..8)
- LEN_W, 16, width of symbol-count input
- WARMUP, 16, discard steps after seeding (0..255)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new sequence; honoured only in IDLE
- key  in  KEY_W  seed, sampled on accepted start
- len  in  LEN_W  symbols to emit, sampled on accepted start
- wm_select  in  1  1: full SYM_W-bit symbols; 0: bit 0 only, upper bits forced 0; sampled on accepted start
- wm_valid  out  1  wm_data valid
- wm_ready  in  1  consumer accepts symbol
- wm_data  out  SYM_W  current symbol
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse at sequence end

## Operation
- LFSR step: out = s[0]; s = s >> 1; if out, s ^= TAPS.
- Symbol bit i (i = 0..SYM_W-1) = out of the i-th step from the current state; wm_data is combinational from the held state, masked per latched wm_select.
- FSM: IDLE, WARM, RUN, FIN.
- IDLE: on start, load s = key, or KEY_W'(1) if key == 0; latch len into count and wm_select. Next: FIN if len == 0; else WARM if WARMUP > 0; else RUN.
- WARM: one LFSR step per cycle, WARMUP cycles, no output; then RUN.
- RUN: wm_valid = 1. On wm_valid & wm_ready: advance s by SYM_W steps, decrement count; if count was 1, go to FIN. Without ready: s, count, wm_data held stable.
- FIN: done = 1 for exactly this cycle, busy = 1; then IDLE.
- start outside IDLE ignored; key/len/wm_select changes outside IDLE ignored.
- count never wraps; len = 2^LEN_W-1 is legal.

## Timing
- Reset values: wm_valid 0, wm_data 0, busy 0, done 0; state IDLE, s 0, count 0.
- rst mid-sequence: next cycle is IDLE with reset values; pending symbol dropped, no done.
- start accepted at edge t: busy high from t+1; wm_valid high from t+1+WARMUP.
- Throughput: one symbol per cycle while wm_ready held high.
- Final accept at edge t: wm_valid low and done high in cycle t+1, done low at t+2 (IDLE).
- len == 0: done in cycle t+1, no wm_valid.
- start asserted in the cycle after FIN (IDLE) is accepted; no dead cycle beyond FIN.
- wm_ready while wm_valid low has no effect.

## Structure
- Package wm_pkg: FSM state enum, default TAPS constant, function lfsr_step(state, taps) returning {next_state, out_bit}.
- Sub-module wm_lfsr_core: state register, seed load with zero-guard, single-step and SYM_W-step unrolled next-state, symbol extraction. Top holds FSM, counter, handshake and masking.

## Test plan
- WARMUP=0, key=16'h0001, len=3, wm_select=1, ready high: wm_data 2'b01, 2'b00, 2'b00 on consecutive cycles; done one cycle after third accept.
- key=16'h0000, WARMUP=0: behaves identically to key=16'h0001 (zero-seed guard), never locks up.
- Back-pressure: ready toggled randomly over len=100; accepted symbol stream matches reference model, wm_data stable while valid & !ready.
- wm_select=0, len=4: wm_data[1] always 0, wm_data[0] matches reference bit-0 stream.
- len=0: done at t+1, wm_valid never asserted; start during RUN ignored (count unchanged).
- rst asserted mid-RUN after 5 accepts: next cycle all outputs 0, no done; subsequent start restarts from new key.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared types and helpers for the watermark keystream generator.
// The LFSR step is defined at the maximum supported width; narrower users zero-extend.
package wm_pkg;

    typedef enum logic [1:0] {
        WM_IDLE = 2'd0,
        WM_WARM = 2'd1,
        WM_RUN  = 2'd2,
        WM_FIN  = 2'd3
    } wm_state_e;

    localparam int LFSR_MAX_W = 32;
    localparam logic [15:0] WM_DEFAULT_TAPS = 16'hB400;

    // Galois step; upper bits stay zero when state and taps are zero-extended.
    function automatic logic [LFSR_MAX_W:0] lfsr_step(input logic [LFSR_MAX_W-1:0] state,
                                                      input logic [LFSR_MAX_W-1:0] taps);
        logic [LFSR_MAX_W-1:0] nxt;
        nxt = state >> 1;
        if (state[0]) begin
            nxt = nxt ^ taps;
        end
        return {nxt, state[0]};
    endfunction

endpackage

// File: rtl/wm_lfsr_core.sv
// LFSR state register with zero-guarded seeding, one-step and SYM_W-step advance,
// and extraction of the current SYM_W-bit symbol.
module wm_lfsr_core
    import wm_pkg::*;
#(
    parameter int              KEY_W = 16,
    parameter logic [KEY_W-1:0] TAPS = KEY_W'(WM_DEFAULT_TAPS),
    parameter int              SYM_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [KEY_W-1:0] key,
    input  logic             step_one,
    input  logic             step_sym,
    output logic [SYM_W-1:0] sym
);

    localparam logic [LFSR_MAX_W-1:0] W_TAPS = LFSR_MAX_W'(TAPS);

    // Held at full package width; bits above KEY_W are constant zero.
    logic [LFSR_MAX_W-1:0] r_state;
    logic [LFSR_MAX_W-1:0] w_seed;
    logic [LFSR_MAX_W-1:0] w_chain [0:SYM_W];
    logic [SYM_W-1:0]      w_sym;

    always_comb begin
        w_seed = LFSR_MAX_W'(key);
        if (key == '0) begin
            w_seed = LFSR_MAX_W'(1);
        end
    end

    always_comb begin
        w_chain    = '{default: '0};
        w_sym      = '0;
        w_chain[0] = r_state;
        for (int i = 0; i < SYM_W; i++) begin
            {w_chain[i+1], w_sym[i]} = lfsr_step(w_chain[i], W_TAPS);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
        end else if (load) begin
            r_state <= w_seed;
        end else if (step_sym) begin
            r_state <= w_chain[SYM_W];
        end else if (step_one) begin
            r_state <= w_chain[1];
        end
    end

    assign sym = w_sym;

endmodule

// File: rtl/wm_keystream_gen.sv
// Key-seeded watermark keystream generator: sequence FSM, symbol counter,
// output handshake and symbol masking around the LFSR core.
module wm_keystream_gen
    import wm_pkg::*;
#(
    parameter int               KEY_W  = 16,
    parameter logic [KEY_W-1:0] TAPS   = KEY_W'(WM_DEFAULT_TAPS),
    parameter int               SYM_W  = 2,
    parameter int               LEN_W  = 16,
    parameter int               WARMUP = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key,
    input  logic [LEN_W-1:0] len,
    input  logic             wm_select,
    output logic             wm_valid,
    input  logic             wm_ready,
    output logic [SYM_W-1:0] wm_data,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_IDLE    = 2'(WM_IDLE);
    localparam logic [1:0] S_WARM    = 2'(WM_WARM);
    localparam logic [1:0] S_RUN     = 2'(WM_RUN);
    localparam logic [1:0] S_FIN     = 2'(WM_FIN);
    localparam logic [7:0] WARM_LAST = 8'((WARMUP > 0) ? (WARMUP - 1) : 0);

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_count;
    logic             r_sel;
    logic [7:0]       r_warm;

    logic             w_start;
    logic             w_accept;
    logic [SYM_W-1:0] w_sym;
    logic [SYM_W-1:0] w_mask;

    // Handshake: a symbol transfers on any edge where wm_valid && wm_ready; while
    // wm_valid is high and wm_ready low, wm_data and the remaining count are held.
    assign w_start  = (r_state == S_IDLE) && start;
    assign w_accept = (r_state == S_RUN) && wm_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_sel   <= 1'b0;
            r_warm  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count <= len;
                        r_sel   <= wm_select;
                        r_warm  <= '0;
                        if (len == '0) begin
                            r_state <= S_FIN;
                        end else if (WARMUP > 0) begin
                            r_state <= S_WARM;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_WARM: begin
                    r_warm <= r_warm + 8'd1;
                    if (r_warm == WARM_LAST) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (wm_ready) begin
                        r_count <= r_count - LEN_W'(1);
                        if (r_count == LEN_W'(1)) begin
                            r_state <= S_FIN;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    wm_lfsr_core #(
        .KEY_W (KEY_W),
        .TAPS  (TAPS),
        .SYM_W (SYM_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (w_start),
        .key      (key),
        .step_one (r_state == S_WARM),
        .step_sym (w_accept),
        .sym      (w_sym)
    );

    // Narrow mode keeps only bit 0; data reads zero outside RUN.
    assign w_mask    = r_sel ? '1 : SYM_W'(1);
    assign wm_valid  = (r_state == S_RUN);
    assign wm_data   = wm_valid ? (w_sym & w_mask) : '0;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_wm_keystream_gen.sv
// Scoreboard bench: two generators (no warm-up and short warm-up) share stimulus;
// a queue-based reference model predicts each symbol stream and done/latency timing.
module tb_wm_keystream_gen;

    localparam int KEY_W  = 16;
    localparam int SYM_W  = 2;
    localparam int LEN_W  = 16;
    localparam int WARM_A = 0;
    localparam int WARM_B = 5;
    localparam logic [KEY_W-1:0] TAPS = 16'hB400;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [KEY_W-1:0] key = '0;
    logic [LEN_W-1:0] len = '0;
    logic             wm_select = 1'b0;
    logic             wm_ready = 1'b0;
    logic             rdy_rand = 1'b0;

    logic             valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic [SYM_W-1:0] data_a, data_b;
    logic [1:0]       dbg_a, dbg_b;

    logic [SYM_W-1:0] exp_a[$];
    logic [SYM_W-1:0] exp_b[$];

    int n_vec = 0;
    int n_fail = 0;
    int acc_cnt [2];
    bit prev_rst [2];
    bit last_acc [2];
    bit zero_start [2];
    bit armed [2];
    bit stall [2];
    logic [SYM_W-1:0] stall_data [2];
    int since [2];

    always #5 clk = ~clk;

    wm_keystream_gen #(.KEY_W(KEY_W), .TAPS(TAPS), .SYM_W(SYM_W), .LEN_W(LEN_W), .WARMUP(WARM_A)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .key(key), .len(len), .wm_select(wm_select),
        .wm_valid(valid_a), .wm_ready(wm_ready), .wm_data(data_a), .busy(busy_a), .done(done_a),
        .dbg_state(dbg_a)
    );

    wm_keystream_gen #(.KEY_W(KEY_W), .TAPS(TAPS), .SYM_W(SYM_W), .LEN_W(LEN_W), .WARMUP(WARM_B)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .key(key), .len(len), .wm_select(wm_select),
        .wm_valid(valid_b), .wm_ready(wm_ready), .wm_data(data_b), .busy(busy_b), .done(done_b),
        .dbg_state(dbg_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic lfsr_bit(inout int unsigned s, output int unsigned b);
        b = s & 1;
        s = s >> 1;
        if (b != 0) s = s ^ 32'(TAPS);
    endtask

    // Reference: seed, discard warm-up bits, then SYM_W bits per symbol, LSB first.
    task automatic push_model(input int idx, input logic [KEY_W-1:0] k, input int n, input bit sel);
        int unsigned s, b, sym;
        int warm;
        warm = (idx == 0) ? WARM_A : WARM_B;
        s = (k == 0) ? 1 : 32'(k);
        for (int w = 0; w < warm; w++) lfsr_bit(s, b);
        for (int j = 0; j < n; j++) begin
            sym = 0;
            for (int i = 0; i < SYM_W; i++) begin
                lfsr_bit(s, b);
                sym = sym | (b << i);
            end
            if (!sel) sym = sym & 1;
            if (idx == 0) exp_a.push_back(SYM_W'(sym));
            else          exp_b.push_back(SYM_W'(sym));
        end
    endtask

    task automatic mon(input int idx, input logic v, input logic [SYM_W-1:0] d, input logic b,
                       input logic dn, input int warm);
        logic [SYM_W-1:0] e;
        bit new_last;
        bit zs;
        int qs;
        string t;
        new_last = 0;
        zs = 0;
        t = (idx == 0) ? "a" : "b";
        if (rst) begin
            prev_rst[idx] = 1; last_acc[idx] = 0; zero_start[idx] = 0;
            armed[idx] = 0; stall[idx] = 0; since[idx] = 1000;
            return;
        end
        if (prev_rst[idx]) begin
            check({t, "_reset_outputs"}, 32'({v, d, b, dn}), 32'(0));
            prev_rst[idx] = 0;
        end else begin
            check({t, "_done"}, 32'(dn), 32'(last_acc[idx] | zero_start[idx]));
        end
        if (stall[idx]) check({t, "_stall_hold"}, 32'({v, d}), 32'({1'b1, stall_data[idx]}));
        if (since[idx] < 1000) since[idx]++;
        if (since[idx] == 1) check({t, "_busy_after_start"}, 32'(b), 32'(1));
        if (armed[idx] && v) begin
            check({t, "_valid_latency"}, 32'(since[idx]), 32'(warm + 1));
            armed[idx] = 0;
        end
        if (v && wm_ready) begin
            qs = (idx == 0) ? exp_a.size() : exp_b.size();
            if (qs == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL %s_extra_symbol: got symbol %0h expected no transfer at %0t", t, d, $time);
            end else begin
                e = (idx == 0) ? exp_a.pop_front() : exp_b.pop_front();
                check({t, "_symbol"}, 32'(d), 32'(e));
                acc_cnt[idx]++;
                if (qs == 1) new_last = 1;
            end
        end
        stall[idx] = v && !wm_ready;
        stall_data[idx] = d;
        if (start && !b) begin
            since[idx] = 0;
            armed[idx] = (len != 0);
            zs = (len == 0);
        end
        last_acc[idx] = new_last;
        zero_start[idx] = zs;
    endtask

    always @(negedge clk) begin
        mon(0, valid_a, data_a, busy_a, done_a, WARM_A);
        mon(1, valid_b, data_b, busy_b, done_b, WARM_B);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while ((busy_a || busy_b) && c < budget) begin
            tick();
            c++;
        end
        if (busy_a || busy_b) begin
            n_vec++;
            n_fail++;
            $display("FAIL wait_idle: busy still high after %0d cycles, expected idle", budget);
        end
    endtask

    task automatic wait_acc(input int n, input int budget);
        int base, c;
        base = acc_cnt[0];
        c = 0;
        while (acc_cnt[0] < base + n && c < budget) begin
            tick();
            c++;
        end
        if (acc_cnt[0] < base + n) begin
            n_vec++;
            n_fail++;
            $display("FAIL wait_acc: got %0d accepts expected %0d", acc_cnt[0] - base, n);
        end
    endtask

    task automatic run_seq(input logic [KEY_W-1:0] k, input int n, input bit sel, input bit rr);
        wait_idle(2000);
        rdy_rand = rr;
        key = k;
        len = LEN_W'(n);
        wm_select = sel;
        start = 1'b1;
        push_model(0, k, n, sel);
        push_model(1, k, n, sel);
        tick();
        start = 1'b0;
        key = KEY_W'($urandom);
        len = LEN_W'($urandom);
        wm_select = 1'($urandom_range(0, 1));
    endtask

    initial begin
        forever begin
            tick();
            wm_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        since[0] = 1000;
        since[1] = 1000;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Known answer from seed 1 for the no-warm-up generator.
        wait_idle(100);
        rdy_rand = 1'b0;
        key = 16'h0001;
        len = LEN_W'(3);
        wm_select = 1'b1;
        start = 1'b1;
        exp_a.push_back(2'b01);
        exp_a.push_back(2'b00);
        exp_a.push_back(2'b00);
        push_model(1, 16'h0001, 3, 1'b1);
        tick();
        start = 1'b0;

        run_seq(16'h0000, 20, 1'b1, 1'b0);
        run_seq(KEY_W'($urandom), 100, 1'b1, 1'b1);
        run_seq(KEY_W'($urandom), 4, 1'b0, 1'b0);
        run_seq(KEY_W'($urandom), 0, 1'b1, 1'b0);

        // A second start mid-sequence must not disturb key, count or stream.
        run_seq(KEY_W'($urandom), 12, 1'b1, 1'b0);
        wait_acc(3, 100);
        start = 1'b1;
        key = KEY_W'($urandom);
        len = LEN_W'(5);
        tick();
        start = 1'b0;

        // Reset after five transfers drops the rest of the sequence.
        run_seq(KEY_W'($urandom), 30, 1'b1, 1'b1);
        wait_acc(5, 200);
        rst = 1'b1;
        exp_a.delete();
        exp_b.delete();
        tick();
        rst = 1'b0;
        run_seq(KEY_W'($urandom), 10, 1'b1, 1'b0);

        for (int r = 0; r < 10; r++) begin
            run_seq(KEY_W'($urandom), (r == 6) ? 0 : $urandom_range(1, 40),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        wait_idle(2000);
        tick();
        tick();
        check("a_queue_left", 32'(exp_a.size()), 32'(0));
        check("b_queue_left", 32'(exp_b.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
